// File: rtl/sll_arbiter.sv
// Round-robin front end for a shared singly-linked-list engine: one operation in
// flight at a time, results routed back to the granted requester, watchdog on WAIT.
module sll_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int OP_WIDTH   = 3,
  parameter int TIMEOUT    = 64,
  localparam int GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ*OP_WIDTH-1:0]    req_op_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr_i,
  output logic [NUM_REQ-1:0]             rsp_valid_o,
  output logic [DATA_WIDTH-1:0]          rsp_data_o,
  output logic [ADDR_WIDTH-1:0]          rsp_next_o,
  output logic                           rsp_fault_o,
  output logic                           rsp_timeout_o,
  output logic                           busy_o,
  output logic [GW-1:0]                  grant_id_o,
  output logic [OP_WIDTH-1:0]            sll_op_o,
  output logic [DATA_WIDTH-1:0]          sll_data_in_o,
  output logic [ADDR_WIDTH-1:0]          sll_addr_in_o,
  output logic                           sll_op_start_o,
  input  logic                           sll_op_done_i,
  input  logic [DATA_WIDTH-1:0]          sll_data_out_i,
  input  logic [ADDR_WIDTH-1:0]          sll_next_node_addr_i,
  input  logic                           sll_fault_i
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  typedef struct packed {
    logic [OP_WIDTH-1:0]   op;
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] addr;
  } req_t;

  req_t [NUM_REQ-1:0] req_a;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign req_a[g] = '{op:   req_op_i[g*OP_WIDTH +: OP_WIDTH],
                        data: req_data_i[g*DATA_WIDTH +: DATA_WIDTH],
                        addr: req_addr_i[g*ADDR_WIDTH +: ADDR_WIDTH]};
  end

  state_e                  state_q;
  logic [GW-1:0]           rr_ptr_q, grant_q;
  logic [CW-1:0]           cnt_q;
  logic [OP_WIDTH-1:0]     sll_op_q;
  logic [DATA_WIDTH-1:0]   sll_data_q, rsp_data_q;
  logic [ADDR_WIDTH-1:0]   sll_addr_q, rsp_next_q;
  logic                    start_q, rsp_fault_q, rsp_to_q;
  logic [NUM_REQ-1:0]      rsp_valid_q;

  logic                    pick_vld_d;
  logic [GW-1:0]           pick_idx_d, scan_idx, rr_ptr_d;

  // Scan from the top offset down so the closest requester above rr_ptr wins last.
  always_comb begin
    pick_vld_d = 1'b0;
    pick_idx_d = '0;
    scan_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = GW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (req_i[scan_idx]) begin
        pick_vld_d = 1'b1;
        pick_idx_d = scan_idx;
      end
    end
  end

  assign rr_ptr_d = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      cnt_q       <= '0;
      sll_op_q    <= '0;
      sll_data_q  <= '0;
      sll_addr_q  <= '0;
      start_q     <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_next_q  <= '0;
      rsp_fault_q <= 1'b0;
      rsp_to_q    <= 1'b0;
    end else begin
      start_q     <= 1'b0;
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: if (pick_vld_d) begin
          grant_q    <= pick_idx_d;
          sll_op_q   <= req_a[pick_idx_d].op;
          sll_data_q <= req_a[pick_idx_d].data;
          sll_addr_q <= req_a[pick_idx_d].addr;
          start_q    <= 1'b1;
          state_q    <= ISSUE;
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          // done has priority over an expiring watchdog in the same cycle
          if (sll_op_done_i) begin
            rsp_data_q           <= sll_data_out_i;
            rsp_next_q           <= sll_next_node_addr_i;
            rsp_fault_q          <= sll_fault_i;
            rsp_to_q             <= 1'b0;
            rsp_valid_q[grant_q] <= 1'b1;
            state_q              <= RESP;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            rsp_data_q           <= '0;
            rsp_next_q           <= '0;
            rsp_fault_q          <= 1'b1;
            rsp_to_q             <= 1'b1;
            rsp_valid_q[grant_q] <= 1'b1;
            state_q              <= RESP;
          end
        end
        RESP: begin
          rr_ptr_q <= rr_ptr_d;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_data_o     = rsp_data_q;
  assign rsp_next_o     = rsp_next_q;
  assign rsp_fault_o    = rsp_fault_q;
  assign rsp_timeout_o  = rsp_to_q;
  assign busy_o         = (state_q != IDLE);
  assign grant_id_o     = grant_q;
  assign sll_op_o       = sll_op_q;
  assign sll_data_in_o  = sll_data_q;
  assign sll_addr_in_o  = sll_addr_q;
  assign sll_op_start_o = start_q;

endmodule

// File: tb/tb_sll_arbiter.sv
// Bench for sll_arbiter: behavioural engine, expectation queue filled at stimulus
// time and drained by a response monitor, plus directed multi-cycle sequences.
module tb_sll_arbiter;
  localparam int N = 4, DW = 8, AW = 4, OW = 3, TO = 64, GW = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req = '0, keep = '0;
  logic [OW-1:0]   r_op   [N];
  logic [DW-1:0]   r_data [N];
  logic [AW-1:0]   r_addr [N];
  logic [N*OW-1:0] req_op;
  logic [N*DW-1:0] req_data;
  logic [N*AW-1:0] req_addr;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_op[g*OW +: OW]   = r_op[g];
    assign req_data[g*DW +: DW] = r_data[g];
    assign req_addr[g*AW +: AW] = r_addr[g];
  end

  logic [N-1:0]  rsp_valid;
  logic [DW-1:0] rsp_data, sll_data_in, eng_dout;
  logic [AW-1:0] rsp_next, sll_addr_in, eng_next;
  logic          rsp_fault, rsp_timeout, busy, sll_op_start;
  logic [GW-1:0] grant_id;
  logic [OW-1:0] sll_op;
  logic          eng_done, eng_flt, inj_done = 1'b0, eng_fault_cfg = 1'b0;
  int            eng_delay = 1, eng_cnt;

  sll_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OP_WIDTH(OW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .req_op_i(req_op), .req_data_i(req_data),
    .req_addr_i(req_addr), .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_next_o(rsp_next),
    .rsp_fault_o(rsp_fault), .rsp_timeout_o(rsp_timeout), .busy_o(busy), .grant_id_o(grant_id),
    .sll_op_o(sll_op), .sll_data_in_o(sll_data_in), .sll_addr_in_o(sll_addr_in),
    .sll_op_start_o(sll_op_start), .sll_op_done_i(eng_done | inj_done),
    .sll_data_out_i(eng_dout), .sll_next_node_addr_i(eng_next), .sll_fault_i(eng_flt));

  // Engine model: echoes data_in, returns addr_in+1; eng_delay=0 means it never finishes.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_done <= 1'b0; eng_cnt <= 0; eng_dout <= '0; eng_next <= '0; eng_flt <= 1'b0;
    end else begin
      eng_done <= 1'b0;
      if ((sll_op_start && eng_delay == 1) || (!sll_op_start && eng_cnt == 1)) begin
        eng_done <= 1'b1;
        eng_dout <= sll_data_in;
        eng_next <= sll_addr_in + 1'b1;
        eng_flt  <= eng_fault_cfg;
      end
      if (sll_op_start && eng_delay > 1) eng_cnt <= eng_delay - 1;
      else if (eng_cnt > 0)              eng_cnt <= eng_cnt - 1;
    end
  end

  int total = 0, bad = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  function automatic void fail(string nm);
    total++; bad++;
    $display("FAIL %s: event not expected / not seen", nm);
  endfunction

  typedef struct {
    int id; logic [OW-1:0] op; logic [DW-1:0] d; logic [AW-1:0] a;
    logic [DW-1:0] xd; logic [AW-1:0] xn; logic xf, xt; int lat;
  } exp_t;
  exp_t q[$];

  function automatic void push_exp(int id, logic [DW-1:0] xd, logic [AW-1:0] xn, logic xf, logic xt);
    exp_t e;
    e.id = id; e.op = r_op[id]; e.d = r_data[id]; e.a = r_addr[id];
    e.xd = xd; e.xn = xn; e.xf = xf; e.xt = xt;
    e.lat = xt ? TO + 1 : eng_delay + 1;
    q.push_back(e);
  endfunction

  function automatic void push_norm(int id);
    push_exp(id, r_data[id], r_addr[id] + 1'b1, eng_fault_cfg, 1'b0);
  endfunction

  // Monitor: checks each start against the head expectation and pops on response.
  int cyc = 0, outst = 0, start_cyc = 0;
  logic start_prev = 1'b0;
  exp_t m;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (!rst_n) begin
      outst = 0; start_prev = 1'b0;
    end else begin
      if (sll_op_start) begin
        chk("start_width", 32'(start_prev), 0);
        chk("outstanding", 32'(outst), 0);
        outst++; start_cyc = cyc;
        if (q.size() == 0) fail("start_unexpected");
        else begin
          chk("grant_id", 32'(grant_id), 32'(q[0].id));
          chk("sll_op",   32'(sll_op), 32'(q[0].op));
          chk("sll_data", 32'(sll_data_in), 32'(q[0].d));
          chk("sll_addr", 32'(sll_addr_in), 32'(q[0].a));
        end
      end
      start_prev = sll_op_start;
      if (rsp_valid != '0) begin
        outst--;
        if (q.size() == 0) fail("rsp_unexpected");
        else begin
          m = q.pop_front();
          chk("rsp_valid",   32'(rsp_valid), 32'(1) << m.id);
          chk("rsp_data",    32'(rsp_data), 32'(m.xd));
          chk("rsp_next",    32'(rsp_next), 32'(m.xn));
          chk("rsp_fault",   32'(rsp_fault), 32'(m.xf));
          chk("rsp_timeout", 32'(rsp_timeout), 32'(m.xt));
          chk("latency",     32'(cyc - start_cyc), 32'(m.lat));
        end
      end
    end
  end

  // Wait for n responses; drop each requester on its pulse unless kept, drop all at the end.
  task automatic run(int n, int budget);
    int cnt = 0;
    for (int t = 0; t < budget && cnt < n; t++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if (rsp_valid[i]) begin
          cnt++;
          if (!keep[i]) req[i] = 1'b0;
        end
    end
    if (cnt < n) fail("rsp_wait_budget");
    req = '0;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_rsp"}, {rsp_valid, rsp_data, rsp_next, rsp_fault, rsp_timeout, busy, 12'h0}, 0);
    chk({tag, "_sll"}, {grant_id, sll_op, sll_data_in, sll_addr_in, sll_op_start, 14'h0}, 0);
  endtask

  typedef struct {
    int id; logic [OW-1:0] op; logic [DW-1:0] d; logic [AW-1:0] a; int dly; logic flt;
    logic [DW-1:0] xd; logic [AW-1:0] xn; logic xf, xt;
  } vec_t;
  vec_t tbl[4];

  initial begin
    for (int i = 0; i < N; i++) begin r_op[i] = '0; r_data[i] = '0; r_addr[i] = '0; end
    tbl[0] = '{2, 3'd1, 8'hA5, 4'd3, 5, 1'b0, 8'hA5, 4'd4, 1'b0, 1'b0};
    tbl[1] = '{1, 3'd7, 8'h00, 4'd0, 0, 1'b0, 8'h00, 4'd0, 1'b1, 1'b1};
    tbl[2] = '{0, 3'd2, 8'h3C, 4'd7, 1, 1'b0, 8'h3C, 4'd8, 1'b0, 1'b0};
    tbl[3] = '{3, 3'd5, 8'hFF, 4'hF, 3, 1'b1, 8'hFF, 4'h0, 1'b1, 1'b0};

    #1 chk_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single requests, including timeout (with late done) and engine fault.
    foreach (tbl[k]) begin
      r_op[tbl[k].id] = tbl[k].op; r_data[tbl[k].id] = tbl[k].d; r_addr[tbl[k].id] = tbl[k].a;
      eng_delay = tbl[k].dly; eng_fault_cfg = tbl[k].flt;
      push_exp(tbl[k].id, tbl[k].xd, tbl[k].xn, tbl[k].xf, tbl[k].xt);
      req[tbl[k].id] = 1'b1;
      run(1, 200);
      if (tbl[k].xt) begin
        repeat (3) @(negedge clk);
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        @(negedge clk);
        chk("late_done_busy", 32'(busy), 0);
      end
      @(negedge clk);
    end

    // All four held: strict rotation starting at 0.
    eng_delay = 2; eng_fault_cfg = 1'b0;
    for (int i = 0; i < N; i++) begin
      r_op[i] = OW'(i + 1); r_data[i] = DW'(8'h10 * i + 8'h07); r_addr[i] = AW'(3 * i + 1);
    end
    for (int k = 0; k < 8; k++) push_norm(k % N);
    keep = '1; req = '1;
    run(8, 400);
    keep = '0;
    @(negedge clk);

    // Fairness: 3 held, 1 arrives mid-operation and is served before 3 again.
    eng_delay = 4;
    push_norm(3);
    keep = 4'b1000; req[3] = 1'b1;
    repeat (3) @(negedge clk);
    chk("fair_busy", 32'(busy), 1);
    req[1] = 1'b1;
    push_norm(1); push_norm(3);
    run(3, 200);
    keep = '0;
    @(negedge clk);

    // Reset during WAIT: pointer at 2, so 3 is granted, then aborted; after release 1 goes first.
    push_norm(1); req[1] = 1'b1;
    run(1, 100);
    @(negedge clk);
    eng_delay = 20;
    push_norm(3);
    req[1] = 1'b1; req[3] = 1'b1;
    begin
      int t;
      for (t = 0; t < 20 && !sll_op_start; t++) @(negedge clk);
      if (!sll_op_start) fail("rst_test_start");
    end
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1 chk_zero("midop_reset");
    q.delete();
    repeat (2) @(negedge clk);
    chk("reset_hold_rsp", 32'(rsp_valid), 0);
    eng_delay = 2;
    push_norm(1); push_norm(3);
    rst_n = 1'b1;
    run(2, 200);
    repeat (3) @(negedge clk);

    chk("queue_empty", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end
endmodule
